// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - precise-exception control: per-stage fault capture, MEM commit, flushes and vector/ERET redirect
// Faults ride with each instruction to MEM; first fault recorded wins, interrupts preempt at commit.
module exc_ctrl #(
  parameter logic [31:0] RESET_VEC  = 32'hbfc00000,
  parameter logic [31:0] KSEG0_BASE = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        IF_valid,
  input  logic [31:0] IF_pc,
  input  logic        IF_bd,
  input  logic        IF_adel,
  input  logic        IF_tlbRefill,
  input  logic        IF_tlbInv,
  input  logic        ID_ri,
  input  logic        ID_sys,
  input  logic        ID_bp,
  input  logic        ID_cpu,
  input  logic [1:0]  ID_cpuNum,
  input  logic        EX_ov,
  input  logic        EX_tr,
  input  logic        MEM_adel,
  input  logic        MEM_ades,
  input  logic        MEM_tlbRefill,
  input  logic        MEM_tlbInv,
  input  logic        MEM_tlbMod,
  input  logic        MEM_isStore,
  input  logic [31:0] MEM_addr,
  input  logic        interrupt,
  input  logic        statusEXL,
  input  logic        statusERL,
  input  logic        statusBEV,
  input  logic        causeIV,
  input  logic        eret,
  input  logic [31:0] regEPC,
  input  logic [31:0] regErrorEPC,
  output logic        excAccept,
  output logic [4:0]  excCode,
  output logic        bdOut,
  output logic [31:0] epcOut,
  output logic [1:0]  copNum,
  output logic [31:0] badVAddr,
  output logic        writeBadVAddr,
  output logic        IF_flush,
  output logic        ID_flush,
  output logic        EX_flush,
  output logic        MEM_flush,
  output logic        redirect,
  output logic [31:0] redirectPC
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        pending;
    logic [4:0]  code;
    logic [31:0] badv;
    logic [1:0]  cop;
    logic        refill;
  } slot_t;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_ERET} state_t;

  state_t      r_state, w_next;
  slot_t       r_id, r_ex, r_mem;
  slot_t       w_if, w_id_m, w_ex_m, w_mem_m;
  logic [4:0]  r_code_q;
  logic        r_refill_q, r_exl_q;
  logic        w_run, w_irq, w_commit, w_eret_go;
  logic [4:0]  w_code;
  logic [31:0] w_base, w_off;

  always_comb begin
    w_if       = '0;
    w_if.valid = IF_valid;
    w_if.pc    = IF_pc;
    w_if.bd    = IF_bd;
    if (IF_valid) begin
      if (IF_adel) begin
        w_if.pending = 1'b1;
        w_if.code    = 5'd4;
        w_if.badv    = IF_pc;
      end else if (IF_tlbRefill || IF_tlbInv) begin
        w_if.pending = 1'b1;
        w_if.code    = 5'd2;
        w_if.badv    = IF_pc;
        w_if.refill  = IF_tlbRefill;
      end
    end
  end

  always_comb begin
    w_id_m = r_id;
    if (r_id.valid && !r_id.pending) begin
      if (ID_cpu) begin
        w_id_m.pending = 1'b1;
        w_id_m.code    = 5'd11;
        w_id_m.cop     = ID_cpuNum;
      end else if (ID_ri) begin
        w_id_m.pending = 1'b1;
        w_id_m.code    = 5'd10;
      end else if (ID_sys) begin
        w_id_m.pending = 1'b1;
        w_id_m.code    = 5'd8;
      end else if (ID_bp) begin
        w_id_m.pending = 1'b1;
        w_id_m.code    = 5'd9;
      end
    end
  end

  always_comb begin
    w_ex_m = r_ex;
    if (r_ex.valid && !r_ex.pending) begin
      if (EX_ov) begin
        w_ex_m.pending = 1'b1;
        w_ex_m.code    = 5'd12;
      end else if (EX_tr) begin
        w_ex_m.pending = 1'b1;
        w_ex_m.code    = 5'd13;
      end
    end
  end

  always_comb begin
    w_mem_m = r_mem;
    if (r_mem.valid && !r_mem.pending) begin
      if (MEM_adel || MEM_ades) begin
        w_mem_m.pending = 1'b1;
        w_mem_m.code    = MEM_adel ? 5'd4 : 5'd5;
        w_mem_m.badv    = MEM_addr;
      end else if (MEM_tlbRefill || MEM_tlbInv) begin
        w_mem_m.pending = 1'b1;
        w_mem_m.code    = MEM_isStore ? 5'd3 : 5'd2;
        w_mem_m.badv    = MEM_addr;
        w_mem_m.refill  = MEM_tlbRefill;
      end else if (MEM_tlbMod) begin
        w_mem_m.pending = 1'b1;
        w_mem_m.code    = 5'd1;
        w_mem_m.badv    = MEM_addr;
      end
    end
  end

  assign w_run     = rst && (r_state == S_RUN);
  assign w_irq     = w_run && w_mem_m.valid && interrupt;
  assign w_commit  = w_irq || (w_run && w_mem_m.valid && w_mem_m.pending);
  assign w_code    = w_irq ? 5'd0 : w_mem_m.code;
  assign w_eret_go = w_run && eret && !w_commit;

  // Refill vector only applies when the fault was taken outside an exception handler
  assign w_base = statusBEV ? (RESET_VEC + 32'h200) : KSEG0_BASE;
  assign w_off  = (r_refill_q && !r_exl_q)           ? 32'h0   :
                  ((r_code_q == 5'd0) && causeIV)    ? 32'h200 : 32'h180;

  always_comb begin
    w_next        = r_state;
    excAccept     = 1'b0;
    excCode       = 5'd0;
    bdOut         = 1'b0;
    epcOut        = 32'h0;
    copNum        = 2'd0;
    badVAddr      = 32'h0;
    writeBadVAddr = 1'b0;
    IF_flush      = 1'b0;
    ID_flush      = 1'b0;
    EX_flush      = 1'b0;
    MEM_flush     = 1'b0;
    redirect      = 1'b0;
    redirectPC    = 32'h0;
    case (r_state)
      S_RUN: begin
        if (w_commit) begin
          excAccept = 1'b1;
          excCode   = w_code;
          bdOut     = w_mem_m.bd;
          epcOut    = w_mem_m.bd ? (w_mem_m.pc - 32'd4) : w_mem_m.pc;
          if (!w_irq) begin
            copNum        = w_mem_m.cop;
            badVAddr      = w_mem_m.badv;
            writeBadVAddr = (w_code >= 5'd1) && (w_code <= 5'd5);
          end
          IF_flush  = 1'b1;
          ID_flush  = 1'b1;
          EX_flush  = 1'b1;
          MEM_flush = 1'b1;
          w_next    = S_FLUSH;
        end else if (w_eret_go) begin
          IF_flush = 1'b1;
          ID_flush = 1'b1;
          w_next   = S_ERET;
        end
      end
      S_FLUSH: begin
        redirect   = rst;
        redirectPC = rst ? (w_base + w_off) : 32'h0;
        w_next     = S_RUN;
      end
      S_ERET: begin
        redirect   = rst;
        redirectPC = !rst ? 32'h0 : (statusERL ? regErrorEPC : regEPC);
        w_next     = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_code_q   <= 5'd0;
      r_refill_q <= 1'b0;
      r_exl_q    <= 1'b0;
    end else if (w_commit) begin
      r_code_q   <= w_code;
      r_refill_q <= !w_irq && w_mem_m.refill;
      r_exl_q    <= statusEXL;
    end
  end

  // A flush must clear its slot even while the pipe is stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_id  <= '0;
      r_ex  <= '0;
      r_mem <= '0;
    end else begin
      if (IF_flush)    r_id <= '0;
      else if (!stall) r_id <= w_if;
      if (ID_flush)    r_ex <= '0;
      else if (!stall) r_ex <= w_id_m;
      if (EX_flush)    r_mem <= '0;
      else if (!stall) r_mem <= w_ex_m;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl with an instruction-level exception model
module tb_exc_ctrl;

  logic clk = 1'b0;
  logic rst, stall, IF_valid, IF_bd, IF_adel, IF_tlbRefill, IF_tlbInv;
  logic [31:0] IF_pc;
  logic ID_ri, ID_sys, ID_bp, ID_cpu;
  logic [1:0] ID_cpuNum;
  logic EX_ov, EX_tr, MEM_adel, MEM_ades, MEM_tlbRefill, MEM_tlbInv, MEM_tlbMod, MEM_isStore;
  logic [31:0] MEM_addr;
  logic interrupt, statusEXL, statusERL, statusBEV, causeIV, eret;
  logic [31:0] regEPC, regErrorEPC;
  logic excAccept, bdOut, writeBadVAddr, IF_flush, ID_flush, EX_flush, MEM_flush, redirect;
  logic [4:0] excCode;
  logic [31:0] epcOut, badVAddr, redirectPC;
  logic [1:0] copNum;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .IF_valid(IF_valid), .IF_pc(IF_pc), .IF_bd(IF_bd), .IF_adel(IF_adel),
    .IF_tlbRefill(IF_tlbRefill), .IF_tlbInv(IF_tlbInv),
    .ID_ri(ID_ri), .ID_sys(ID_sys), .ID_bp(ID_bp), .ID_cpu(ID_cpu), .ID_cpuNum(ID_cpuNum),
    .EX_ov(EX_ov), .EX_tr(EX_tr),
    .MEM_adel(MEM_adel), .MEM_ades(MEM_ades), .MEM_tlbRefill(MEM_tlbRefill),
    .MEM_tlbInv(MEM_tlbInv), .MEM_tlbMod(MEM_tlbMod), .MEM_isStore(MEM_isStore), .MEM_addr(MEM_addr),
    .interrupt(interrupt), .statusEXL(statusEXL), .statusERL(statusERL), .statusBEV(statusBEV),
    .causeIV(causeIV), .eret(eret), .regEPC(regEPC), .regErrorEPC(regErrorEPC),
    .excAccept(excAccept), .excCode(excCode), .bdOut(bdOut), .epcOut(epcOut), .copNum(copNum),
    .badVAddr(badVAddr), .writeBadVAddr(writeBadVAddr),
    .IF_flush(IF_flush), .ID_flush(ID_flush), .EX_flush(EX_flush), .MEM_flush(MEM_flush),
    .redirect(redirect), .redirectPC(redirectPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic bd, if_adel, if_refill, if_inv;
    logic id_ri, id_sys, id_bp, id_cpu;
    logic [1:0] cpunum;
    logic ex_ov, ex_tr;
    logic mem_adel, mem_ades, mem_refill, mem_inv, mem_mod, mem_store;
    logic [31:0] addr;
    logic is_eret;
  } instr_t;

  typedef struct {
    bit has;
    logic [4:0] code;
    logic [31:0] badv;
    logic refill;
    logic [1:0] cop;
  } exc_t;

  int n_checks = 0, n_err = 0;
  instr_t prog [0:7];
  int n_prog, fetch_ptr, m_id, m_ex, m_mem, stall_from, stall_to;
  bit m_redir;
  logic [31:0] m_rpc;
  int acc_cnt, redir_cnt, eret_cnt;
  logic [4:0] cap_code;
  logic [31:0] cap_epc, cap_badv, cap_rpc;
  logic cap_bd, cap_wbv;
  logic [1:0] cap_cop;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(logic [31:0] pc);
    instr_t p;
    p.pc = pc; p.bd = 0; p.if_adel = 0; p.if_refill = 0; p.if_inv = 0;
    p.id_ri = 0; p.id_sys = 0; p.id_bp = 0; p.id_cpu = 0; p.cpunum = 0;
    p.ex_ov = 0; p.ex_tr = 0; p.mem_adel = 0; p.mem_ades = 0; p.mem_refill = 0;
    p.mem_inv = 0; p.mem_mod = 0; p.mem_store = 0; p.addr = 0; p.is_eret = 0;
    return p;
  endfunction

  // Oldest stage's fault first, then priority within the stage
  function automatic exc_t get_exc(instr_t p);
    exc_t x;
    x.has = 1; x.code = 0; x.badv = 0; x.refill = 0; x.cop = 0;
    if (p.if_adel) begin x.code = 4; x.badv = p.pc; end
    else if (p.if_refill || p.if_inv) begin x.code = 2; x.badv = p.pc; x.refill = p.if_refill; end
    else if (p.id_cpu) begin x.code = 11; x.cop = p.cpunum; end
    else if (p.id_ri) x.code = 10;
    else if (p.id_sys) x.code = 8;
    else if (p.id_bp) x.code = 9;
    else if (p.ex_ov) x.code = 12;
    else if (p.ex_tr) x.code = 13;
    else if (p.mem_adel) begin x.code = 4; x.badv = p.addr; end
    else if (p.mem_ades) begin x.code = 5; x.badv = p.addr; end
    else if (p.mem_refill || p.mem_inv) begin
      x.code = p.mem_store ? 5'd3 : 5'd2; x.badv = p.addr; x.refill = p.mem_refill;
    end
    else if (p.mem_mod) begin x.code = 1; x.badv = p.addr; end
    else x.has = 0;
    return x;
  endfunction

  task automatic start();
    n_prog = 0; fetch_ptr = 0; m_id = -1; m_ex = -1; m_mem = -1;
    m_redir = 0; stall_from = -1; stall_to = -1;
  endtask

  task automatic add(instr_t p);
    prog[n_prog] = p;
    n_prog++;
  endtask

  task automatic drive(int c);
    instr_t f, i, e, m;
    f = mk(0); i = mk(0); e = mk(0); m = mk(0);
    if (fetch_ptr < n_prog) f = prog[fetch_ptr];
    if (m_id >= 0) i = prog[m_id];
    if (m_ex >= 0) e = prog[m_ex];
    if (m_mem >= 0) m = prog[m_mem];
    stall = (c >= stall_from) && (c < stall_to);
    IF_valid = (fetch_ptr < n_prog); IF_pc = f.pc; IF_bd = f.bd;
    IF_adel = f.if_adel; IF_tlbRefill = f.if_refill; IF_tlbInv = f.if_inv;
    ID_ri = i.id_ri; ID_sys = i.id_sys; ID_bp = i.id_bp; ID_cpu = i.id_cpu; ID_cpuNum = i.cpunum;
    EX_ov = e.ex_ov; EX_tr = e.ex_tr; eret = e.is_eret;
    MEM_adel = m.mem_adel; MEM_ades = m.mem_ades; MEM_tlbRefill = m.mem_refill;
    MEM_tlbInv = m.mem_inv; MEM_tlbMod = m.mem_mod; MEM_isStore = m.mem_store; MEM_addr = m.addr;
  endtask

  task automatic check_update();
    exc_t x;
    instr_t p;
    bit irq, commit, erg;
    logic [4:0] code_e;
    logic [31:0] base, off;
    x.has = 0; x.code = 0; x.badv = 0; x.refill = 0; x.cop = 0;
    p = mk(0);
    if (m_mem >= 0) begin p = prog[m_mem]; x = get_exc(p); end
    irq    = !m_redir && (m_mem >= 0) && interrupt;
    commit = irq || (!m_redir && (m_mem >= 0) && x.has);
    erg    = !m_redir && !commit && eret;
    code_e = irq ? 5'd0 : x.code;
    chk("excAccept", 32'(excAccept), 32'(commit));
    if (commit) begin
      chk("excCode", 32'(excCode), 32'(code_e));
      chk("epcOut", epcOut, p.bd ? p.pc - 32'd4 : p.pc);
      chk("bdOut", 32'(bdOut), 32'(p.bd));
      chk("writeBadVAddr", 32'(writeBadVAddr), 32'(!irq && code_e >= 1 && code_e <= 5));
      if (!irq) begin
        chk("badVAddr", badVAddr, x.badv);
        chk("copNum", 32'(copNum), 32'(x.cop));
      end
    end
    chk("IF_flush", 32'(IF_flush), 32'(commit || erg));
    chk("ID_flush", 32'(ID_flush), 32'(commit || erg));
    chk("EX_flush", 32'(EX_flush), 32'(commit));
    chk("MEM_flush", 32'(MEM_flush), 32'(commit));
    chk("redirect", 32'(redirect), 32'(m_redir));
    if (m_redir) chk("redirectPC", redirectPC, m_rpc);
    if (excAccept) begin
      acc_cnt++; cap_code = excCode; cap_epc = epcOut; cap_bd = bdOut;
      cap_badv = badVAddr; cap_wbv = writeBadVAddr; cap_cop = copNum;
    end
    if (redirect) begin redir_cnt++; cap_rpc = redirectPC; end
    if (IF_flush && !excAccept) eret_cnt++;
    if (commit) begin
      base = statusBEV ? 32'hbfc00200 : 32'h80000000;
      off  = (!irq && x.refill && !statusEXL) ? 32'h0 : (irq && causeIV) ? 32'h200 : 32'h180;
      m_rpc = base + off; m_redir = 1;
    end else if (erg) begin
      m_rpc = statusERL ? regErrorEPC : regEPC; m_redir = 1;
    end else m_redir = 0;
    m_mem = commit ? -1 : stall ? m_mem : m_ex;
    m_ex  = (commit || erg) ? -1 : stall ? m_ex : m_id;
    if (commit || erg) begin m_id = -1; fetch_ptr = n_prog; end
    else if (!stall) begin
      m_id = (fetch_ptr < n_prog) ? fetch_ptr : -1;
      if (fetch_ptr < n_prog) fetch_ptr++;
    end
  endtask

  task automatic run(int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      drive(c);
      @(negedge clk);
      check_update();
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_inputs();
    start();
    drive(0);
    stall = 0; interrupt = 0; statusEXL = 0; statusERL = 0; statusBEV = 0; causeIV = 0;
    regEPC = 0; regErrorEPC = 0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_acc"}, 32'(excAccept), 0);
    chk({tag, "_code"}, 32'(excCode), 0);
    chk({tag, "_epc"}, epcOut, 0);
    chk({tag, "_flush"}, 32'({IF_flush, ID_flush, EX_flush, MEM_flush}), 0);
    chk({tag, "_redir"}, 32'(redirect), 0);
    chk({tag, "_rpc"}, redirectPC, 0);
    chk({tag, "_wbv"}, 32'(writeBadVAddr), 0);
  endtask

  instr_t t;
  int a0, r0, e0;

  initial begin
    rst = 0;
    clear_inputs();
    acc_cnt = 0; redir_cnt = 0; eret_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1;

    // RI at ID
    start(); t = mk(32'h80001000); t.id_ri = 1; add(t);
    a0 = acc_cnt; run(6);
    chk("ri_count", 32'(acc_cnt - a0), 1);
    chk("ri_code", 32'(cap_code), 10);
    chk("ri_epc", cap_epc, 32'h80001000);
    chk("ri_rpc", cap_rpc, 32'h80000180);

    // load DTLB refill, EXL=0 then EXL=1
    start(); t = mk(32'h80001100); t.mem_refill = 1; t.addr = 32'h00400123; add(t);
    run(6);
    chk("tlbl_code", 32'(cap_code), 2);
    chk("tlbl_wbv", 32'(cap_wbv), 1);
    chk("tlbl_badv", cap_badv, 32'h00400123);
    chk("tlbl_rpc", cap_rpc, 32'h80000000);
    statusEXL = 1;
    start(); add(t); run(6);
    chk("tlbl_exl_rpc", cap_rpc, 32'h80000180);
    statusEXL = 0;

    // delay-slot overflow
    start(); t = mk(32'h80002004); t.bd = 1; t.ex_ov = 1; add(t);
    run(6);
    chk("ov_code", 32'(cap_code), 12);
    chk("ov_epc", cap_epc, 32'h80002000);
    chk("ov_bd", 32'(cap_bd), 1);

    // older AdES beats younger Sys
    start();
    t = mk(32'h80001200); t.mem_ades = 1; t.mem_store = 1; t.addr = 32'h1001; add(t);
    t = mk(32'h80001204); t.id_sys = 1; add(t);
    a0 = acc_cnt; run(8);
    chk("ades_count", 32'(acc_cnt - a0), 1);
    chk("ades_code", 32'(cap_code), 5);
    chk("ades_badv", cap_badv, 32'h1001);

    // priority within and across stages
    start(); t = mk(32'h80001500); t.id_cpu = 1; t.cpunum = 2; t.id_ri = 1; add(t);
    run(6);
    chk("cpu_code", 32'(cap_code), 11);
    chk("cpu_cop", 32'(cap_cop), 2);
    start(); t = mk(32'h80001603); t.if_adel = 1; t.ex_ov = 1; add(t);
    run(6);
    chk("ifadel_code", 32'(cap_code), 4);
    chk("ifadel_badv", cap_badv, 32'h80001603);

    // interrupt, IV=1 BEV=1
    interrupt = 1; causeIV = 1; statusBEV = 1;
    start(); add(mk(32'h80001300)); run(6);
    chk("int_code", 32'(cap_code), 0);
    chk("int_wbv", 32'(cap_wbv), 0);
    chk("int_rpc", cap_rpc, 32'hbfc00400);
    interrupt = 0; causeIV = 0; statusBEV = 0;

    // ERET with a stall before it reaches EX
    regEPC = 32'h80003000; regErrorEPC = 32'h80004000;
    start(); add(mk(32'h80001400)); t = mk(32'h80001404); t.is_eret = 1; add(t);
    add(mk(32'h80001408)); stall_from = 1; stall_to = 3;
    a0 = acc_cnt; r0 = redir_cnt; e0 = eret_cnt; run(8);
    chk("eret_noacc", 32'(acc_cnt - a0), 0);
    chk("eret_flushes", 32'(eret_cnt - e0), 1);
    chk("eret_redirs", 32'(redir_cnt - r0), 1);
    chk("eret_rpc", cap_rpc, 32'h80003000);
    statusERL = 1;
    start(); add(mk(32'h80001500)); t = mk(32'h80001504); t.is_eret = 1; add(t);
    run(6);
    chk("eret_erl_rpc", cap_rpc, 32'h80004000);
    statusERL = 0;

    // commit in the same cycle as ERET wins
    start();
    t = mk(32'h80001600); t.mem_adel = 1; t.addr = 32'h5; add(t);
    t = mk(32'h80001604); t.is_eret = 1; add(t);
    e0 = eret_cnt; run(7);
    chk("ovr_code", 32'(cap_code), 4);
    chk("ovr_rpc", cap_rpc, 32'h80000180);
    chk("ovr_noeret", 32'(eret_cnt - e0), 0);

    // reset during FLUSH: no redirect, back to RUN
    start(); t = mk(32'h80001700); t.id_ri = 1; add(t);
    run(4);
    rst = 0; start(); drive(0);
    @(negedge clk);
    check_all_zero("rstflush");
    @(posedge clk); #1;
    rst = 1;
    start(); run(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Precise-exception control unit for the 5-stage CPU.
- Collects exception flags raised in IF/ID/EX/MEM and carries them with each instruction to MEM, where the oldest exception or a pending interrupt is committed.
- Drives the CP0 exception-capture interface: excAccept, excCode, BD, EPC, BadVAddr and CE.
- Produces the pipeline flushes and the PC redirect for exception vectors and ERET.

Parameters:
- RESET_VEC, 32'hbfc00000, boot vector base (BEV=1 exception base = RESET_VEC + 32'h200)
- KSEG0_BASE, 32'h80000000, exception base when BEV=0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- stall  in  1  global pipeline stall; pipe registers hold
- IF_valid  in  1  IF instruction valid
- IF_pc  in  32  IF PC
- IF_bd  in  1  IF instruction is in a delay slot
- IF_adel  in  1  fetch address error
- IF_tlbRefill  in  1  ITLB miss (no entry)
- IF_tlbInv  in  1  ITLB entry invalid
- ID_ri  in  1  reserved instruction
- ID_sys  in  1  SYSCALL
- ID_bp  in  1  BREAK
- ID_cpu  in  1  coprocessor unusable
- ID_cpuNum  in  2  unusable coprocessor number
- EX_ov  in  1  arithmetic overflow
- EX_tr  in  1  trap
- MEM_adel, MEM_ades  in  1 each  load/store address error
- MEM_tlbRefill  in  1  DTLB miss
- MEM_tlbInv  in  1  DTLB invalid
- MEM_tlbMod  in  1  store to clean page
- MEM_isStore  in  1  MEM access is a store
- MEM_addr  in  32  data virtual address
- interrupt, statusEXL, statusERL, statusBEV, causeIV  in  1 each  from CP0
- eret  in  1  ERET at EX, from CP0
- regEPC, regErrorEPC  in  32 each  from CP0
- excAccept  out  1  exception committed this cycle
- excCode  out  5  ExcCode
- bdOut  out  1  Cause.BD
- epcOut  out  32  EPC value
- copNum  out  2  Cause.CE
- badVAddr  out  32  faulting address
- writeBadVAddr  out  1  BadVAddr/Context/EntryHi.VPN2 write strobe
- IF_flush, ID_flush, EX_flush, MEM_flush  out  1 each  stage flushes
- redirect  out  1  PC redirect strobe
- redirectPC  out  32  redirect target

Behaviour:
- Reset (rst=0 at clk edge): all pipe slots invalid, FSM=RUN, all outputs 0.
- Pipe slots ID/EX/MEM each hold {valid, pc, bd, pending, code[4:0], badv[31:0], cop[1:0], refill}.
- Slots advance only when stall=0; a flushed stage loads valid=0.
- First fault wins: a stage's flags are merged into its slot only if pending=0.
- IF codes, in priority order: AdEL=4 (badv=pc), then TLBL=2 (refill=IF_tlbRefill, badv=pc).
- ID codes, in priority order: CpU=11 (cop=ID_cpuNum), RI=10, Sys=8, Bp=9.
- EX codes, in priority order: Ov=12, Tr=13.
- MEM codes, in priority order:
  - AdEL=4 or AdES=5
  - TLBL=2 or TLBS=3, refill set on MEM_tlbRefill
  - Mod=1
  - all with badv=MEM_addr.
- Commit (combinational, cycle T), MEM slot valid and FSM=RUN:
  - interrupt=1 takes precedence: code 0, no BadVAddr write.
  - otherwise pending=1 commits the slot's code.
  - Commit is independent of stall.
- On commit:
  - excAccept=1; epcOut = bd ? pc-4 : pc; bdOut=bd.
  - writeBadVAddr=1 for codes 1-5.
  - IF/ID/EX/MEM_flush=1.
  - FSM -> FLUSH.
- FLUSH (T+1):
  - redirect=1; excAccept suppressed; FSM -> RUN.
  - redirectPC base = statusBEV ? RESET_VEC+32'h200 : KSEG0_BASE.
  - offset = 0 if refill & ~EXL_at_T; 32'h200 if code 0 & causeIV; else 32'h180.
  - EXL_at_T is statusEXL sampled in T.
- ERET at EX with no commit in the same cycle:
  - IF_flush=ID_flush=1.
  - Next cycle redirect=1, redirectPC = statusERL ? regErrorEPC : regEPC.
  - Commit in the same cycle overrides ERET.
- rst mid-FLUSH: return to RUN with no redirect.

Test Plan:
- RI at ID, PC 32'h80001000, BEV=0, EXL=0 -> 2 cycles later: excAccept=1, excCode=10, epcOut=32'h80001000, all flushes; next cycle redirect=1, redirectPC=32'h80000180.
- Load DTLB refill, addr 32'h00400123, EXL=0, BEV=0 -> excCode=2, writeBadVAddr=1, badVAddr=32'h00400123, redirectPC=32'h80000000; repeat with EXL=1 -> 32'h80000180.
- Delay-slot Ov at PC 32'h80002004 -> epcOut=32'h80002000, bdOut=1, excCode=12.
- Older MEM AdES (addr 32'h1001) plus younger ID Sys -> only AdES commits, excCode=5, one excAccept pulse.
- Interrupt with IV=1, BEV=1 -> excCode=0, writeBadVAddr=0, redirectPC=32'hbfc00400.
- ERET with ERL=0, regEPC=32'h80003000 -> IF/ID flush, next cycle redirectPC=32'h80003000; stall high mid-sequence leaves slots unchanged.
